mem_bus_arbiter: RTL and testbench

- Shares one SRAM-like memory bus between the pipeline's instruction-fetch port and its data (load/store) port.
- Sits between the datapath (pcF / aluoutM_addr / writedataM / mem_wenM / readdataM) and the memory-side bridge.
- Allows one transaction outstanding at a time. Data has priority, with a starvation limit for fetch.
- Generates per-port stall signals that feed the hazard unit's stallF/stallM inputs.

---
 rtl/mem_bus_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like memory bus between the instruction-fetch port and the
// data (load/store) port. One transaction is outstanding at a time; data wins
// arbitration unless fetch has been passed over STARVE_LIMIT times in a row.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   inst_*            fetch port: req/addr in; rdata/done registered; stall comb
//   data_*            load/store port: req/wen/addr/wdata in; rdata/done
//                     registered; stall comb
//   bus_*             memory-side request (registered) and addr_ok/data_ok/rdata
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  // fetch port
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_done,
  output logic                inst_stall,
  // data port
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_done,
  output logic                data_stall,
  // memory bus
  output logic                bus_req,
  output logic                bus_wr,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IREQ  = 3'd1,
    IWAIT = 3'd2,
    DREQ  = 3'd3,
    DWAIT = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   starve_cnt, starve_cnt_nxt;

  logic               bus_req_nxt;
  logic               bus_wr_nxt;
  logic [STRB_W-1:0]  bus_wstrb_nxt;
  logic [ADDR_W-1:0]  bus_addr_nxt;
  logic [DATA_W-1:0]  bus_wdata_nxt;
  logic [DATA_W-1:0]  inst_rdata_nxt;
  logic [DATA_W-1:0]  data_rdata_nxt;
  logic               inst_done_nxt;
  logic               data_done_nxt;

  logic               inst_pend;
  logic               data_pend;
  logic               under_limit;

  // A port whose done pulse is high this cycle has already been served.
  assign inst_pend   = inst_req & ~inst_done;
  assign data_pend   = data_req & ~data_done;
  assign under_limit = (starve_cnt < CNT_W'(STARVE_LIMIT));

  assign inst_stall  = inst_req & ~inst_done;
  assign data_stall  = data_req & ~data_done;

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      bus_req    <= 1'b0;
      bus_wr     <= 1'b0;
      bus_wstrb  <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      inst_rdata <= '0;
      data_rdata <= '0;
      inst_done  <= 1'b0;
      data_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      bus_req    <= bus_req_nxt;
      bus_wr     <= bus_wr_nxt;
      bus_wstrb  <= bus_wstrb_nxt;
      bus_addr   <= bus_addr_nxt;
      bus_wdata  <= bus_wdata_nxt;
      inst_rdata <= inst_rdata_nxt;
      data_rdata <= data_rdata_nxt;
      inst_done  <= inst_done_nxt;
      data_done  <= data_done_nxt;
    end
  end

  // Next-state, arbitration and next-output logic.
  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    bus_req_nxt    = bus_req;
    bus_wr_nxt     = bus_wr;
    bus_wstrb_nxt  = bus_wstrb;
    bus_addr_nxt   = bus_addr;
    bus_wdata_nxt  = bus_wdata;
    inst_rdata_nxt = inst_rdata;
    data_rdata_nxt = data_rdata;
    inst_done_nxt  = 1'b0;
    data_done_nxt  = 1'b0;

    unique case (state)
      IDLE: begin
        if (data_pend && (!inst_pend || under_limit)) begin
          state_nxt     = DREQ;
          bus_req_nxt   = 1'b1;
          bus_wr_nxt    = |data_wen;
          bus_wstrb_nxt = data_wen;
          bus_addr_nxt  = data_addr;
          bus_wdata_nxt = data_wdata;
          // Count data grants that passed over a waiting fetch.
          if (inst_pend) begin
            if (under_limit) begin
              starve_cnt_nxt = starve_cnt + CNT_W'(1);
            end
          end else begin
            starve_cnt_nxt = '0;
          end
        end else if (inst_pend) begin
          state_nxt      = IREQ;
          bus_req_nxt    = 1'b1;
          bus_wr_nxt     = 1'b0;
          bus_wstrb_nxt  = '0;
          bus_addr_nxt   = inst_addr;
          bus_wdata_nxt  = '0;
          starve_cnt_nxt = '0;
        end
      end
      IREQ: begin
        if (bus_addr_ok) begin
          state_nxt   = IWAIT;
          bus_req_nxt = 1'b0;
        end
      end
      DREQ: begin
        if (bus_addr_ok) begin
          state_nxt   = DWAIT;
          bus_req_nxt = 1'b0;
        end
      end
      IWAIT: begin
        if (bus_data_ok) begin
          state_nxt      = RESP;
          inst_rdata_nxt = bus_rdata;
          inst_done_nxt  = 1'b1;
        end
      end
      DWAIT: begin
        if (bus_data_ok) begin
          state_nxt     = RESP;
          data_done_nxt = 1'b1;
          // Stores complete without disturbing the last load value.
          if (!bus_wr) begin
            data_rdata_nxt = bus_rdata;
          end
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a latency-configurable bus slave model,
// fetch/data requester tasks and hand-computed expected grant sequences.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_done;
  logic        inst_stall;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        data_stall;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int errors = 0;
  int checks = 0;

  mem_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_done(inst_done), .inst_stall(inst_stall),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_done(data_done),
    .data_stall(data_stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a == 32'h40) ? 32'h2402_0005 : {a[15:0], 16'hC0DE};
  endfunction

  // Accepted-request log, filled by the slave at addr_ok time.
  logic [31:0] log_addr[$];
  logic        log_wr[$];
  logic [3:0]  log_strb[$];
  logic [31:0] log_wdata[$];
  logic [3:0]  log_cnt[$];

  task automatic log_clear();
    log_addr.delete(); log_wr.delete(); log_strb.delete();
    log_wdata.delete(); log_cnt.delete();
  endtask

  // Bus slave: addr_ok addr_lat cycles after bus_req, data_ok data_lat later.
  bit          slave_en  = 1'b1;
  bit          hold_addr = 1'b0;
  int          addr_lat  = 1;
  int          data_lat  = 2;
  int          a_cnt;
  int          d_cnt;
  bit          d_busy;
  logic [31:0] cur_addr;

  initial begin
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    a_cnt = 0; d_cnt = 0; d_busy = 1'b0; cur_addr = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; a_cnt = 0; d_busy = 1'b0;
      end else if (slave_en) begin
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        if (d_busy) begin
          if (d_cnt == 0) begin
            bus_data_ok = 1'b1; bus_rdata = mem_rd(cur_addr); d_busy = 1'b0;
          end else begin
            d_cnt--;
          end
        end else if (bus_req && !hold_addr) begin
          if (a_cnt >= addr_lat) begin
            bus_addr_ok = 1'b1; a_cnt = 0; d_busy = 1'b1; d_cnt = data_lat - 1;
            cur_addr = bus_addr;
            log_addr.push_back(bus_addr); log_wr.push_back(bus_wr);
            log_strb.push_back(bus_wstrb); log_wdata.push_back(bus_wdata);
            log_cnt.push_back(dut.starve_cnt);
          end else begin
            a_cnt++;
          end
        end
      end
    end
  end

  // Wait (bounded) for a done pulse on one port; n = clock edges waited.
  task automatic wait_done(input bit is_data, output int n);
    logic d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      d = is_data ? data_done : inst_done;
    end while (!d && n < 100);
    chk(is_data ? "data_done_seen" : "inst_done_seen", 32'(d), 32'd1);
  endtask

  logic [31:0] exp_starve_addr [7] = '{32'h200, 32'h204, 32'h208, 32'h20C,
                                       32'h80, 32'h210, 32'h214};
  logic [31:0] exp_starve_cnt  [7] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n1;
    int n2;
    rst = 1'b0; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0;
    data_wen = '0; data_addr = '0; data_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_done", 32'({inst_done, data_done}), 32'd0);
    chk("rst_rdata", inst_rdata | data_rdata, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Single fetch
    log_clear();
    inst_addr = 32'h40; inst_req = 1'b1;
    #1 chk("f_stall_req", 32'(inst_stall), 32'd1);
    wait_done(1'b0, n);
    chk("f_latency", 32'(n), 32'd5);
    chk("f_rdata", inst_rdata, 32'h2402_0005);
    chk("f_stall_at_done", 32'(inst_stall), 32'd0);
    inst_req = 1'b0;
    @(posedge clk); #1;
    chk("f_done_once", 32'(inst_done), 32'd0);
    chk("f_grants", 32'(log_addr.size()), 32'd1);
    chk("f_bus_addr", log_addr[0], 32'h40);
    chk("f_bus_wr", 32'(log_wr[0]), 32'd0);

    // Simultaneous requests: data first, then fetch
    log_clear();
    inst_addr = 32'h44; data_addr = 32'h180; data_wen = 4'b0000;
    inst_req = 1'b1; data_req = 1'b1;
    fork
      begin wait_done(1'b1, n1); data_req = 1'b0; end
      begin wait_done(1'b0, n2); inst_req = 1'b0; end
    join
    chk("s_grants", 32'(log_addr.size()), 32'd2);
    chk("s_first_addr", log_addr[0], 32'h180);
    chk("s_second_addr", log_addr[1], 32'h44);
    chk("s_cnt_data", 32'(log_cnt[0]), 32'd1);
    chk("s_cnt_inst", 32'(log_cnt[1]), 32'd0);
    chk("s_order", 32'(n1 < n2), 32'd1);
    chk("s_data_rdata", data_rdata, 32'h0180_C0DE);
    chk("s_inst_rdata", inst_rdata, 32'h0044_C0DE);
    @(posedge clk); #1;

    // Store
    log_clear();
    data_addr = 32'h100; data_wen = 4'b0011; data_wdata = 32'hDEAD_BEEF; data_req = 1'b1;
    wait_done(1'b1, n);
    chk("w_stall_at_done", 32'(data_stall), 32'd0);
    data_req = 1'b0; data_wen = 4'b0000;
    chk("w_latency", 32'(n), 32'd5);
    chk("w_bus_wr", 32'(log_wr[0]), 32'd1);
    chk("w_bus_wstrb", 32'(log_strb[0]), 32'h3);
    chk("w_bus_wdata", log_wdata[0], 32'hDEAD_BEEF);
    chk("w_bus_addr", log_addr[0], 32'h100);
    chk("w_rdata_kept", data_rdata, 32'h0180_C0DE);
    @(posedge clk); #1;

    // Starvation: four data grants, one fetch, then data again
    log_clear();
    inst_addr = 32'h80; data_addr = 32'h200; data_wen = 4'b0000;
    inst_req = 1'b1; data_req = 1'b1;
    fork
      begin wait_done(1'b0, n1); inst_req = 1'b0; end
      begin
        for (int i = 0; i < 6; i++) begin
          data_addr = 32'h200 + 32'(4 * i);
          wait_done(1'b1, n2);
        end
        data_req = 1'b0;
      end
    join
    chk("st_grants", 32'(log_addr.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("st_addr%0d", i), log_addr[i], exp_starve_addr[i]);
      chk($sformatf("st_cnt%0d", i), 32'(log_cnt[i]), exp_starve_cnt[i]);
    end
    chk("st_data_rdata", data_rdata, 32'h0214_C0DE);
    chk("st_inst_rdata", inst_rdata, 32'h0080_C0DE);
    @(posedge clk); #1;

    // Back-pressure: addr_ok withheld for 10 cycles
    log_clear();
    hold_addr = 1'b1;
    inst_addr = 32'h300; inst_req = 1'b1;
    data_addr = 32'h500; data_wen = 4'hF; data_wdata = 32'h1234_5678; data_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_bus_req", 32'(bus_req), 32'd1);
      chk("bp_bus_addr", bus_addr, 32'h500);
      chk("bp_bus_wdata", bus_wdata, 32'h1234_5678);
      chk("bp_dones", 32'({inst_done, data_done}), 32'd0);
      chk("bp_stalls", 32'({inst_stall, data_stall}), 32'h3);
    end
    hold_addr = 1'b0;
    fork
      begin wait_done(1'b1, n1); data_req = 1'b0; data_wen = 4'h0; end
      begin wait_done(1'b0, n2); inst_req = 1'b0; end
    join
    chk("bp_order0", log_addr[0], 32'h500);
    chk("bp_order1", log_addr[1], 32'h300);
    chk("bp_inst_rdata", inst_rdata, 32'h0300_C0DE);
    chk("bp_data_rdata", data_rdata, 32'h0214_C0DE);
    @(posedge clk); #1;

    // Reset while waiting for load data, then a stale data_ok
    data_lat = 6;
    data_addr = 32'h400; data_wen = 4'h0; data_req = 1'b1;
    n = 0;
    while (!bus_req && n < 20) begin @(posedge clk); #1; n++; end
    while (bus_req && n < 40) begin @(posedge clk); #1; n++; end
    chk("r_reached_wait", 32'(bus_req || n >= 40), 32'd0);
    @(negedge clk);
    rst = 1'b0; data_req = 1'b0; slave_en = 1'b0;
    #1;
    chk("r_bus_req", 32'(bus_req), 32'd0);
    chk("r_bus_wr", 32'({bus_wr, bus_wstrb}), 32'd0);
    chk("r_bus_addr", bus_addr, 32'd0);
    chk("r_bus_wdata", bus_wdata, 32'd0);
    chk("r_dones", 32'({inst_done, data_done}), 32'd0);
    chk("r_inst_rdata", inst_rdata, 32'd0);
    chk("r_data_rdata", data_rdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    bus_data_ok = 1'b1; bus_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    bus_data_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("r_stale_dones", 32'({inst_done, data_done}), 32'd0);
      chk("r_stale_bus_req", 32'(bus_req), 32'd0);
      @(posedge clk); #1;
    end
    chk("r_stale_rdata", data_rdata, 32'd0);
    data_lat = 2; slave_en = 1'b1;
    log_clear();
    inst_addr = 32'h40; inst_req = 1'b1;
    wait_done(1'b0, n);
    inst_req = 1'b0;
    chk("r_after_latency", 32'(n), 32'd5);
    chk("r_after_rdata", inst_rdata, 32'h2402_0005);
    chk("r_after_addr", log_addr[0], 32'h40);
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
